// File: rtl/case_3_mul_pkg.sv
// Shared constants and helpers for the pipelined multiply-accumulate block.
package case_3_mul_pkg;

  localparam logic SGN_UNSIGNED = 1'b0;
  localparam logic SGN_SIGNED   = 1'b1;

  // One guard bit per operand keeps any mix of signed/unsigned exact.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

endpackage

// File: rtl/case_3_mul_pipe_mac_if.sv
// Input beat and result handshake bundle for case_3_mul_pipe_mac.
interface case_3_mul_pipe_mac_if #(
  parameter int din0_WIDTH = 7,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 11
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  sgn0;
  logic                  sgn1;
  logic                  acc_en;
  logic                  acc_clr;
  logic                  out_vld;
  logic                  out_rdy;
  logic [dout_WIDTH-1:0] dout;

  modport master (
    output in_vld, din0, din1, sgn0, sgn1, acc_en, acc_clr, out_rdy,
    input  in_rdy, out_vld, dout
  );

  modport slave (
    input  in_vld, din0, din1, sgn0, sgn1, acc_en, acc_clr, out_rdy,
    output in_rdy, out_vld, dout
  );
endinterface

// File: rtl/case_3_mul_pipe_reg.sv
// Data plus valid pipeline register that advances only when ce is high.
module case_3_mul_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d_in,
  input  logic         vld_in,
  output logic [W-1:0] d_out,
  output logic         vld_out
);

  logic [W-1:0] data_q, data_d;
  logic         vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (ce) begin
      data_d = d_in;
      vld_d  = vld_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign d_out   = data_q;
  assign vld_out = vld_q;

endmodule

// File: rtl/case_3_mul_pipe_mac.sv
// Pipelined signed/unsigned multiplier with optional accumulation and a
// whole-pipeline stall whenever the output register is held by backpressure.
module case_3_mul_pipe_mac
  import case_3_mul_pkg::*;
#(
  parameter int din0_WIDTH = 7,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 11,
  parameter int NUM_STAGE  = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  case_3_mul_pipe_mac_if.slave  io
);

  localparam int PW      = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int NUM_MID = (NUM_STAGE >= 2) ? NUM_STAGE - 2 : 0;
  localparam int MID_W   = dout_WIDTH + 2;

  logic                  ce;
  logic                  out_vld_q, out_vld_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic [dout_WIDTH-1:0] acc_q, acc_d;

  logic [din0_WIDTH-1:0] m_din0;
  logic [din1_WIDTH-1:0] m_din1;
  logic                  m_sgn0, m_sgn1, m_acc_en, m_acc_clr, m_vld;

  assign ce         = !(out_vld_q && !io.out_rdy);
  assign io.in_rdy  = ce;
  assign io.out_vld = out_vld_q;
  assign io.dout    = dout_q;

  // With a single stage the multiplier feeds the output register straight from the ports.
  if (NUM_STAGE >= 2) begin : g_s1
    logic [din0_WIDTH-1:0] din0_q, din0_d;
    logic [din1_WIDTH-1:0] din1_q, din1_d;
    logic                  sgn0_q, sgn0_d, sgn1_q, sgn1_d;
    logic                  acc_en_q, acc_en_d, acc_clr_q, acc_clr_d;
    logic                  vld_q, vld_d;

    always_comb begin
      din0_d    = din0_q;
      din1_d    = din1_q;
      sgn0_d    = sgn0_q;
      sgn1_d    = sgn1_q;
      acc_en_d  = acc_en_q;
      acc_clr_d = acc_clr_q;
      vld_d     = vld_q;
      if (ce) begin
        din0_d    = io.din0;
        din1_d    = io.din1;
        sgn0_d    = io.sgn0;
        sgn1_d    = io.sgn1;
        acc_en_d  = io.acc_en;
        acc_clr_d = io.acc_clr;
        vld_d     = io.in_vld;
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        din0_q    <= '0;
        din1_q    <= '0;
        sgn0_q    <= 1'b0;
        sgn1_q    <= 1'b0;
        acc_en_q  <= 1'b0;
        acc_clr_q <= 1'b0;
        vld_q     <= 1'b0;
      end else begin
        din0_q    <= din0_d;
        din1_q    <= din1_d;
        sgn0_q    <= sgn0_d;
        sgn1_q    <= sgn1_d;
        acc_en_q  <= acc_en_d;
        acc_clr_q <= acc_clr_d;
        vld_q     <= vld_d;
      end
    end

    assign m_din0    = din0_q;
    assign m_din1    = din1_q;
    assign m_sgn0    = sgn0_q;
    assign m_sgn1    = sgn1_q;
    assign m_acc_en  = acc_en_q;
    assign m_acc_clr = acc_clr_q;
    assign m_vld     = vld_q;
  end else begin : g_s0
    assign m_din0    = io.din0;
    assign m_din1    = io.din1;
    assign m_sgn0    = io.sgn0;
    assign m_sgn1    = io.sgn1;
    assign m_acc_en  = io.acc_en;
    assign m_acc_clr = io.acc_clr;
    assign m_vld     = io.in_vld;
  end

  logic [din0_WIDTH:0]   ext0;
  logic [din1_WIDTH:0]   ext1;
  logic signed [PW-1:0]  prod;
  logic [dout_WIDTH-1:0] prod_fit;

  // The size cast sign-extends or truncates the exact product to the result width.
  always_comb begin
    ext0     = (m_sgn0 == SGN_SIGNED) ? {m_din0[din0_WIDTH-1], m_din0} : {1'b0, m_din0};
    ext1     = (m_sgn1 == SGN_SIGNED) ? {m_din1[din1_WIDTH-1], m_din1} : {1'b0, m_din1};
    prod     = PW'($signed(ext0)) * PW'($signed(ext1));
    prod_fit = dout_WIDTH'(prod);
  end

  logic [MID_W-1:0] mid_data [NUM_MID+1];
  logic [NUM_MID:0] mid_vld;

  assign mid_data[0] = {m_acc_en, m_acc_clr, prod_fit};
  assign mid_vld[0]  = m_vld;

  for (genvar k = 0; k < NUM_MID; k++) begin : g_mid
    case_3_mul_pipe_reg #(.W(MID_W)) u_stage (
      .clk     (ap_clk),
      .rst_n   (ap_rst_n),
      .ce      (ce),
      .d_in    (mid_data[k]),
      .vld_in  (mid_vld[k]),
      .d_out   (mid_data[k+1]),
      .vld_out (mid_vld[k+1])
    );
  end

  logic [MID_W-1:0]      ent_data;
  logic                  ent_vld, ent_acc_en, ent_acc_clr;
  logic [dout_WIDTH-1:0] ent_prod, acc_base, acc_sum;

  assign ent_data    = mid_data[NUM_MID];
  assign ent_vld     = mid_vld[NUM_MID];
  assign ent_acc_en  = ent_data[MID_W-1];
  assign ent_acc_clr = ent_data[MID_W-2];
  assign ent_prod    = ent_data[dout_WIDTH-1:0];

  always_comb begin
    acc_base  = ent_acc_clr ? '0 : acc_q;
    acc_sum   = acc_base + ent_prod;
    acc_d     = acc_q;
    dout_d    = dout_q;
    out_vld_d = out_vld_q;
    if (ce) begin
      out_vld_d = ent_vld;
      if (ent_vld) begin
        if (ent_acc_en) begin
          acc_d  = acc_sum;
          dout_d = acc_sum;
        end else begin
          dout_d = ent_prod;
          if (ent_acc_clr) acc_d = '0;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_vld_q <= 1'b0;
      dout_q    <= '0;
      acc_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      dout_q    <= dout_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_case_3_mul_pipe_mac.sv
// Directed self-checking bench for case_3_mul_pipe_mac at default parameters.
module tb_case_3_mul_pipe_mac;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  int   n_cmp    = 0;
  int   n_fail   = 0;

  case_3_mul_pipe_mac_if #(.din0_WIDTH(7), .din1_WIDTH(4), .dout_WIDTH(11)) io ();

  case_3_mul_pipe_mac #(
    .din0_WIDTH (7),
    .din1_WIDTH (4),
    .dout_WIDTH (11),
    .NUM_STAGE  (3)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .io       (io.slave)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] d0, input logic [3:0] d1,
                               input logic s0, input logic s1,
                               input logic en, input logic clr);
    io.in_vld  = 1'b1;
    io.din0    = d0;
    io.din1    = d1;
    io.sgn0    = s0;
    io.sgn1    = s1;
    io.acc_en  = en;
    io.acc_clr = clr;
  endtask

  task automatic applyIdle();
    io.in_vld  = 1'b0;
    io.din0    = '0;
    io.din1    = '0;
    io.sgn0    = 1'b0;
    io.sgn1    = 1'b0;
    io.acc_en  = 1'b0;
    io.acc_clr = 1'b0;
  endtask

  // Each call compares out_vld, dout and in_rdy against hand-computed values.
  task automatic checkOutput(input string tag, input logic exp_vld,
                             input logic [10:0] exp_dout, input logic exp_rdy);
    n_cmp++;
    assert (io.out_vld === exp_vld) else begin
      n_fail++;
      $error("[TB] FAIL %s out_vld observed=%0b expected=%0b", tag, io.out_vld, exp_vld);
    end
    n_cmp++;
    assert (io.dout === exp_dout) else begin
      n_fail++;
      $error("[TB] FAIL %s dout observed=%h expected=%h", tag, io.dout, exp_dout);
    end
    n_cmp++;
    assert (io.in_rdy === exp_rdy) else begin
      n_fail++;
      $error("[TB] FAIL %s in_rdy observed=%0b expected=%0b", tag, io.in_rdy, exp_rdy);
    end
  endtask

  initial begin
    io.out_rdy = 1'b1;
    applyIdle();
    #1;
    checkOutput("rst_held", 1'b0, 11'h000, 1'b1);
    step(); step();
    ap_rst_n = 1'b1;
    step();
    checkOutput("rst_state", 1'b0, 11'h000, 1'b1);

    $display("[TB] signed x signed latency");
    applyStimulus(7'h40, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); applyIdle();
    checkOutput("ss_e1", 1'b0, 11'h000, 1'b1);
    step();
    checkOutput("ss_e2", 1'b0, 11'h000, 1'b1);
    step();
    checkOutput("ss_e3", 1'b1, 11'h200, 1'b1);
    step();
    checkOutput("ss_one_cycle", 1'b0, 11'h200, 1'b1);

    $display("[TB] unsigned and mixed");
    applyStimulus(7'd127, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(7'h40, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); applyIdle();
    step();
    checkOutput("uu_max", 1'b1, 11'h771, 1'b1);
    step();
    checkOutput("su_neg", 1'b1, 11'h440, 1'b1);
    step();
    checkOutput("mix_idle", 1'b0, 11'h440, 1'b1);

    $display("[TB] accumulate");
    applyStimulus(7'd10, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(7'd10, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(7'd10, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); applyIdle();
    checkOutput("acc_50", 1'b1, 11'h032, 1'b1);
    step();
    checkOutput("acc_100", 1'b1, 11'h064, 1'b1);
    step();
    checkOutput("acc_150", 1'b1, 11'h096, 1'b1);
    step();
    checkOutput("acc_idle", 1'b0, 11'h096, 1'b1);

    $display("[TB] accumulator wrap");
    applyStimulus(7'd127, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(7'd127, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); applyIdle();
    step();
    checkOutput("wrap_1905", 1'b1, 11'h771, 1'b1);
    step();
    checkOutput("wrap_3810", 1'b1, 11'h6E2, 1'b1);
    step();
    checkOutput("wrap_idle", 1'b0, 11'h6E2, 1'b1);

    $display("[TB] clear without accumulate");
    applyStimulus(7'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(7'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); applyIdle();
    step();
    checkOutput("clr_prod", 1'b1, 11'h006, 1'b1);
    step();
    checkOutput("clr_acc1", 1'b1, 11'h001, 1'b1);
    step();
    checkOutput("clr_idle", 1'b0, 11'h001, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(7'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(7'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(7'd4, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp_first", 1'b1, 11'h001, 1'b1);
    io.out_rdy = 1'b0;
    applyStimulus(7'd6, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("bp_stall0", 1'b1, 11'h001, 1'b0);
    step();
    checkOutput("bp_stall1", 1'b1, 11'h001, 1'b0);
    step();
    checkOutput("bp_stall2", 1'b1, 11'h001, 1'b0);
    step();
    checkOutput("bp_stall3", 1'b1, 11'h001, 1'b0);
    io.out_rdy = 1'b1;
    #1;
    checkOutput("bp_release", 1'b1, 11'h001, 1'b1);
    step(); applyIdle();
    checkOutput("bp_b2", 1'b1, 11'h006, 1'b1);
    step();
    checkOutput("bp_b3", 1'b1, 11'h014, 1'b1);
    step();
    checkOutput("bp_b4", 1'b1, 11'h02A, 1'b1);
    step();
    checkOutput("bp_idle", 1'b0, 11'h02A, 1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(7'd3, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    step(); applyIdle();
    checkOutput("mid_acc10", 1'b1, 11'h00A, 1'b1);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_async", 1'b0, 11'h000, 1'b1);
    step();
    checkOutput("mid_rst_hold", 1'b0, 11'h000, 1'b1);
    ap_rst_n = 1'b1;
    applyStimulus(7'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); applyIdle();
    checkOutput("post_rst_e1", 1'b0, 11'h000, 1'b1);
    step();
    checkOutput("post_rst_e2", 1'b0, 11'h000, 1'b1);
    step();
    checkOutput("post_rst_acc", 1'b1, 11'h006, 1'b1);
    step();
    checkOutput("post_rst_idle", 1'b0, 11'h006, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
